// File: rtl/iter_divider.sv
`default_nettype none
// ============================================================================
// Module   : iter_divider
// Purpose  : Multi-cycle radix-2 restoring integer divider with valid/ready
//            handshakes on both sides and a divide-by-zero flag. One division
//            in flight; one quotient bit is produced per cycle.
// Ports    : clk, rst (sync, active-high)
//            in_valid / in_ready / numer / denom     operand handshake
//            out_valid / out_ready / quotient /
//            remain / div_by_zero                    result handshake
// Options  : ITER_DIV_SIGNED_EN - two's complement operands and results.
//            Adds a FIX cycle, so latency is WIDTH+1 instead of WIDTH.
// Revision : 1.0 - initial release
// ============================================================================
module iter_divider #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] numer,
    input  logic [WIDTH-1:0] denom,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remain,
    output logic             div_by_zero
);

    localparam int c_CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2,
        FIX  = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_next;

    logic [WIDTH-1:0]   r_quo;   // holds the dividend, shifted out MSB first as quotient bits shift in
    logic [WIDTH-1:0]   r_rem;
    logic [WIDTH-1:0]   r_den;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_dbz;

    logic [WIDTH:0]     w_shift;
    logic               w_ge;
    logic [WIDTH-1:0]   w_numer_op;
    logic [WIDTH-1:0]   w_denom_op;

`ifdef ITER_DIV_SIGNED_EN
    logic               r_nsign;  // remainder takes the dividend's sign
    logic               r_qsign;  // quotient negative when operand signs differ

    assign w_numer_op = numer[WIDTH-1] ? -numer : numer;
    assign w_denom_op = denom[WIDTH-1] ? -denom : denom;
`else
    assign w_numer_op = numer;
    assign w_denom_op = denom;
`endif

    // One WIDTH+1 bit compare: the shifted remainder can reach 2*denom-1,
    // which overflows WIDTH bits once denom >= 2^(WIDTH-1).
    assign w_shift = {r_rem, r_quo[WIDTH-1]};
    assign w_ge    = (w_shift >= {1'b0, r_den});

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_next = (denom == '0) ? DONE : BUSY;
                end
            end
            BUSY: begin
                if (r_cnt == '0) begin
`ifdef ITER_DIV_SIGNED_EN
                    w_next = FIX;
`else
                    w_next = DONE;
`endif
                end
            end
            FIX: begin
                w_next = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_next = IDLE;
                end
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_quo   <= '0;
            r_rem   <= '0;
            r_den   <= '0;
            r_cnt   <= '0;
            r_dbz   <= 1'b0;
`ifdef ITER_DIV_SIGNED_EN
            r_nsign <= 1'b0;
            r_qsign <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_cnt <= c_CNT_W'(WIDTH - 1);
                        if (denom == '0) begin
                            // Remainder reports the raw dividend, sign included.
                            r_quo <= '1;
                            r_rem <= numer;
                            r_dbz <= 1'b1;
                        end else begin
                            r_quo <= w_numer_op;
                            r_den <= w_denom_op;
                            r_rem <= '0;
                            r_dbz <= 1'b0;
`ifdef ITER_DIV_SIGNED_EN
                            r_nsign <= numer[WIDTH-1];
                            r_qsign <= numer[WIDTH-1] ^ denom[WIDTH-1];
`endif
                        end
                    end
                end
                BUSY: begin
                    // When w_ge holds the true difference is below denom, so
                    // modulo-2^WIDTH subtraction of the low bits is exact.
                    r_rem <= w_ge ? (w_shift[WIDTH-1:0] - r_den) : w_shift[WIDTH-1:0];
                    r_quo <= {r_quo[WIDTH-2:0], w_ge};
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - c_CNT_W'(1);
                    end
                end
`ifdef ITER_DIV_SIGNED_EN
                FIX: begin
                    // Most-negative / -1 yields magnitude 2^(WIDTH-1), which
                    // reads back as most-negative: the required wrap.
                    if (r_qsign) begin
                        r_quo <= -r_quo;
                    end
                    if (r_nsign) begin
                        r_rem <= -r_rem;
                    end
                end
`endif
                default: begin
                end
            endcase
        end
    end

    assign quotient    = r_quo;
    assign remain      = r_rem;
    assign div_by_zero = r_dbz;

endmodule
`default_nettype wire

// File: doc/iter_divider.md
Name: iter_divider

Overview:
Parametrised, multi-cycle radix-2 restoring integer divider with valid/ready handshakes on input and output. It is the sequential successor to the combinational division core used for 20/5-style checks. It will sit in the n-body force pipeline, dividing accumulated numerators by distance terms without a long combinational path. It adds a divide-by-zero flag, output backpressure and an optional signed mode.

Parameters:
WIDTH, 16, operand and result width in bits (numer, denom, quotient, remain); legal range 2..64.

Ports:
clk  input  1  system clock; all state updates on the rising edge
rst  input  1  synchronous, active-high reset
in_valid  input  1  numer/denom are valid
in_ready  output  1  divider can accept an operand pair
numer  input  WIDTH  dividend
denom  input  WIDTH  divisor
out_valid  output  1  quotient/remain/div_by_zero are valid
out_ready  input  1  consumer accepts the result
quotient  output  WIDTH  numer / denom
remain  output  WIDTH  numer % denom
div_by_zero  output  1  set with a result when denom was 0

Behaviour:
- Reset (rst=1 at an edge): state=IDLE; in_ready=1; out_valid=0; quotient=0; remain=0; div_by_zero=0; iteration counter=0. Reset wins over every other event. An in-flight division is discarded and is never reported.
- FSM states: IDLE, BUSY, DONE.
- IDLE: in_ready=1, out_valid=0. The accept edge (in_valid && in_ready) latches numer and denom.
  - If denom==0, go to DONE.
  - Otherwise go to BUSY with the partial remainder cleared and counter=WIDTH-1.
- BUSY: in_ready=0. Each cycle:
  - shift {rem, quo} left by 1, bringing in the next numer MSB;
  - if rem >= denom, subtract denom and set the quotient LSB to 1.
  - Compare and subtract run at WIDTH+1 bits, so there is no overflow at denom >= 2^(WIDTH-1).
  - When counter==0, go to DONE; otherwise decrement the counter.
- Latency: out_valid rises exactly WIDTH cycles after the accept edge (16 for WIDTH=16). For divide-by-zero it rises 1 cycle after the accept edge.
- DONE: out_valid=1 and in_ready=0. quotient, remain and div_by_zero stay stable until the handshake.
  - At the edge where out_ready=1, go to IDLE and clear out_valid.
  - out_ready=0 holds DONE indefinitely with the outputs unchanged.
- Divide by zero: quotient = all ones, remain = numer, div_by_zero=1. For any other result div_by_zero=0.
- One operation in flight; no pipelining. in_ready depends only on state, not combinationally on out_ready. The next accept is possible at the earliest on the cycle after the output handshake.
- numer and denom are ignored outside the accept edge. in_valid may drop or change freely while the block is not ready.
- No combinational path from any input to any output.

Optional Feature:
ITER_DIV_SIGNED_EN
- Defined: operands and results are two's complement.
  - At accept, take magnitudes of numer and denom and record both signs.
  - BUSY performs the unsigned iteration on the magnitudes.
  - One extra FIX cycle between BUSY and DONE conditionally negates the results. Latency becomes WIDTH+1.
  - Quotient truncates toward zero; remainder takes the sign of numer.
  - Most-negative / -1 gives quotient = most-negative (wrap), remain=0, div_by_zero=0.
  - Divide by zero gives quotient = -1, remain = numer, latency 1.
- Undefined: unsigned only. There is no FIX state and latency is WIDTH.

Test Plan:
1. WIDTH=16, unsigned: numer=20, denom=5 accepted, out_ready=1 -> out_valid exactly 16 cycles later; quotient=4, remain=0, div_by_zero=0; in_ready returns 1 on the next cycle.
2. Boundary values: 65535/1 -> 65535 r0. 65535/65535 -> 1 r0. 1000/33 -> 30 r10. 0/7 -> 0 r0. 32768/40000 -> 0 r32768. Run back-to-back; each accept lands on the first cycle in_ready=1.
3. Divide by zero: 7/0 -> out_valid 1 cycle after accept; quotient=16'hFFFF, remain=7, div_by_zero=1; the following 9/3 gives div_by_zero=0, quotient=3.
4. Backpressure: 100/7 with out_ready=0 for 10 cycles after out_valid -> quotient=14, remain=2 held stable; in_ready=0 throughout; released on the out_ready edge.
5. Reset mid-operation: accept 500/3, assert rst at cycle 5 of BUSY -> next cycle in_ready=1, out_valid=0, outputs 0; the following 9/2 -> 4 r1 with normal latency; the aborted result never appears.
6. With ITER_DIV_SIGNED_EN:
   - -20/3 -> -6 r-2, 17-cycle latency.
   - 20/-3 -> -6 r2.
   - -32768/-1 -> -32768 r0.
   - -5/0 -> quotient=-1, remain=-5, div_by_zero=1.
